// File: rtl/instr_queue_multi_pkg.sv
// Shared types for the instruction queue: fetch entry as seen by the issue stage,
// exception and branch-prediction sub-records, and frontend-wide constants.
package instr_queue_multi_pkg;

    localparam int unsigned PKG_VLEN        = 64;
    localparam int unsigned INSTR_PER_FETCH = 4;

    localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;

    typedef struct packed {
        logic [63:0]          cause;
        logic [PKG_VLEN-1:0]  tval;
        logic                 valid;
    } exception_t;

    typedef struct packed {
        logic                 valid;
        logic [PKG_VLEN-1:0]  predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [PKG_VLEN-1:0]  address;
        logic [31:0]          instruction;
        branchpredict_sbe_t   branch_predict;
        exception_t           ex;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue_bank.sv
// Small synchronous FIFO used both for the per-lane instruction banks and for the
// predicted-target queue. Push when full and pop when empty are ignored.
module instr_queue_bank #(
    parameter int unsigned DEPTH = 2,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dtype             mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage is not reset; the counters alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_queue_multi.sv
// Instruction queue between the frontend realigner and issue: stores the accepted
// prefix of each fetch packet across rotating banks and issues up to NR_ISSUE in order.
module instr_queue_multi
    import instr_queue_multi_pkg::*;
#(
    parameter int unsigned NR_LANES   = INSTR_PER_FETCH,
    parameter int unsigned LANE_DEPTH = 2,
    parameter int unsigned ADDR_DEPTH = 4,
    parameter int unsigned NR_ISSUE   = 2,
    parameter int unsigned VLEN       = PKG_VLEN
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NR_LANES-1:0]           valid_i,
    input  logic [NR_LANES-1:0][31:0]     instr_i,
    input  logic [NR_LANES-1:0][VLEN-1:0] addr_i,
    input  logic [NR_LANES-1:0]           taken_i,
    input  logic [VLEN-1:0]               predict_address_i,
    input  logic                          exception_i,
    output logic                          ready_o,
    output logic                          replay_o,
    output logic [VLEN-1:0]               replay_addr_o,
    output fetch_entry_t [NR_ISSUE-1:0]   fetch_entry_o,
    output logic [NR_ISSUE-1:0]           fetch_entry_valid_o,
    input  logic [NR_ISSUE-1:0]           fetch_entry_ack_i
);

    localparam int unsigned LANE_W = $clog2(NR_LANES);
    localparam int unsigned CNT_W  = LANE_W + 1;
    localparam int unsigned OCC_W  = $clog2(NR_LANES * LANE_DEPTH + 1);

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            taken;
        exception_t      ex;
    } entry_t;

    logic [LANE_W-1:0] idx_is_q;
    logic [LANE_W-1:0] idx_ds_q;
    logic [OCC_W-1:0]  occ_q;

    logic [CNT_W-1:0]  cand;
    logic [CNT_W-1:0]  n_fit;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  ack_cnt;
    logic              last_taken;
    exception_t        ex_in;

    logic [NR_LANES-1:0] bank_push;
    logic [NR_LANES-1:0] bank_pop;
    logic [NR_LANES-1:0] bank_full;
    logic [NR_LANES-1:0] bank_empty;
    entry_t              bank_wdata [NR_LANES];
    entry_t              bank_rdata [NR_LANES];
    logic [LANE_W-1:0]   lane_of_bank [NR_LANES];

    logic              addr_push;
    logic              addr_pop;
    logic              addr_full;
    logic              addr_empty;
    logic [VLEN-1:0]   addr_head;

    // Candidate prefix: run of valid lanes from lane 0, ending at the first taken one.
    always_comb begin
        logic stop;
        cand = '0;
        stop = 1'b0;
        for (int k = 0; k < NR_LANES; k++) begin
            if (!stop && valid_i[k]) begin
                cand = CNT_W'(k + 1);
                if (taken_i[k]) begin
                    stop = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
        if (exception_i) begin
            cand = CNT_W'(valid_i[0]);
        end
        if (rst_i || flush_i) begin
            cand = '0;
        end
    end

    assign last_taken = (cand != '0) && !exception_i && taken_i[LANE_W'(cand - 1'b1)];

    always_comb begin
        logic stop;
        n_fit = '0;
        stop  = 1'b0;
        for (int k = 0; k < NR_LANES; k++) begin
            if (!stop && (CNT_W'(k) < cand)) begin
                if (!bank_full[idx_is_q + LANE_W'(k)]) begin
                    n_fit = CNT_W'(k + 1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // A taken branch without room for its target is refetched rather than stored.
    assign n         = (last_taken && addr_full && (n_fit == cand)) ? cand - 1'b1 : n_fit;
    assign addr_push = last_taken && (n == cand);

    assign replay_o      = (n < cand);
    assign replay_addr_o = replay_o ? addr_i[LANE_W'(n)] : '0;

    always_comb begin
        ex_in = '0;
        if (exception_i) begin
            ex_in.valid = 1'b1;
            ex_in.cause = INSTR_PAGE_FAULT;
            ex_in.tval  = addr_i[0];
        end
    end

    always_comb begin
        for (int b = 0; b < NR_LANES; b++) begin
            lane_of_bank[b]     = LANE_W'(b) - idx_is_q;
            bank_push[b]        = ({1'b0, lane_of_bank[b]} < n);
            bank_wdata[b].instr = instr_i[lane_of_bank[b]];
            bank_wdata[b].addr  = addr_i[lane_of_bank[b]];
            bank_wdata[b].taken = taken_i[lane_of_bank[b]] & ~exception_i;
            bank_wdata[b].ex    = ex_in;
        end
    end

    for (genvar g = 0; g < NR_LANES; g++) begin : gen_bank
        instr_queue_bank #(
            .DEPTH (LANE_DEPTH),
            .dtype (entry_t)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (bank_push[g]),
            .data_i  (bank_wdata[g]),
            .pop_i   (bank_pop[g]),
            .data_o  (bank_rdata[g]),
            .full_o  (bank_full[g]),
            .empty_o (bank_empty[g])
        );
    end

    instr_queue_bank #(
        .DEPTH (ADDR_DEPTH),
        .dtype (logic [VLEN-1:0])
    ) u_addr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (addr_push),
        .data_i  (predict_address_i),
        .pop_i   (addr_pop),
        .data_o  (addr_head),
        .full_o  (addr_full),
        .empty_o (addr_empty)
    );

    // A port is shown only behind a valid, non-taken predecessor, so at most one
    // taken entry (and one target pop) can leave per cycle.
    always_comb begin
        logic              prev_ok;
        logic              pop_ok;
        logic [LANE_W-1:0] pb;
        fetch_entry_valid_o = '0;
        fetch_entry_o       = '0;
        bank_pop            = '0;
        addr_pop            = 1'b0;
        ack_cnt             = '0;
        prev_ok             = 1'b1;
        pop_ok              = 1'b1;
        for (int p = 0; p < NR_ISSUE; p++) begin
            pb = idx_ds_q + LANE_W'(p);
            fetch_entry_valid_o[p] = prev_ok & ~bank_empty[pb];
            if (fetch_entry_valid_o[p]) begin
                fetch_entry_o[p].address                        = bank_rdata[pb].addr;
                fetch_entry_o[p].instruction                    = bank_rdata[pb].instr;
                fetch_entry_o[p].ex                             = bank_rdata[pb].ex;
                fetch_entry_o[p].branch_predict.valid           = bank_rdata[pb].taken;
                fetch_entry_o[p].branch_predict.predict_address =
                    (bank_rdata[pb].taken && !addr_empty) ? addr_head : '0;
            end
            if (fetch_entry_valid_o[p] && fetch_entry_ack_i[p] && pop_ok) begin
                bank_pop[pb] = 1'b1;
                ack_cnt      = ack_cnt + 1'b1;
                addr_pop     = addr_pop | bank_rdata[pb].taken;
            end else begin
                pop_ok = 1'b0;
            end
            prev_ok = fetch_entry_valid_o[p] & ~bank_rdata[pb].taken;
        end
    end

    assign ready_o = (occ_q <= OCC_W'(NR_LANES * (LANE_DEPTH - 1))) && !addr_full;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            idx_is_q <= '0;
            idx_ds_q <= '0;
            occ_q    <= '0;
        end else begin
            idx_is_q <= idx_is_q + LANE_W'(n);
            idx_ds_q <= idx_ds_q + LANE_W'(ack_cnt);
            occ_q    <= occ_q + OCC_W'(n) - OCC_W'(ack_cnt);
        end
    end

endmodule

// File: tb/tb_instr_queue_multi.sv
// Directed bench for instr_queue_multi with a scoreboard of expected issued entries.
module tb_instr_queue_multi;
    import instr_queue_multi_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic [3:0]              valid_i;
    logic [3:0][31:0]        instr_i;
    logic [3:0][63:0]        addr_i;
    logic [3:0]              taken_i;
    logic [63:0]             predict_address_i;
    logic                    exception_i;
    logic                    ready_o;
    logic                    replay_o;
    logic [63:0]             replay_addr_o;
    fetch_entry_t [1:0]      fetch_entry_o;
    logic [1:0]              fetch_entry_valid_o;
    logic [1:0]              fetch_entry_ack_i;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        tk;
        logic        exv;
        logic [63:0] bp;
    } exp_t;

    exp_t sb[$];
    exp_t e_tmp;
    int   checks   = 0;
    int   failures = 0;

    instr_queue_multi dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .valid_i             (valid_i),
        .instr_i             (instr_i),
        .addr_i              (addr_i),
        .taken_i             (taken_i),
        .predict_address_i   (predict_address_i),
        .exception_i         (exception_i),
        .ready_o             (ready_o),
        .replay_o            (replay_o),
        .replay_addr_o       (replay_addr_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ack_i   (fetch_entry_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    always @(posedge clk_i) begin
        assert (!(fetch_entry_ack_i[1] && !fetch_entry_ack_i[0])) else begin
            failures++;
            $error("FAIL ack_order observed=%b expected=ack1 only with ack0", fetch_entry_ack_i);
        end
    end

    function automatic logic [31:0] mk_instr(input logic [63:0] a);
        return {16'h00A5, a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_entry(input string tag, input fetch_entry_t obs, input exp_t e);
        chk({tag, "_addr"}, obs.address, e.addr);
        chk({tag, "_instr"}, 64'(obs.instruction), 64'(e.instr));
        chk({tag, "_bpv"}, 64'(obs.branch_predict.valid), 64'(e.tk));
        chk({tag, "_exv"}, 64'(obs.ex.valid), 64'(e.exv));
        if (e.tk) chk({tag, "_bpaddr"}, obs.branch_predict.predict_address, e.bp);
        if (e.exv) begin
            chk({tag, "_tval"}, obs.ex.tval, e.addr);
            chk({tag, "_cause"}, obs.ex.cause, INSTR_PAGE_FAULT);
        end
    endtask

    // Drive one packet at the falling edge, check the combinational replay, and
    // record the entries the queue is expected to accept.
    task automatic drive(input string tag, input logic [3:0] v, input logic [3:0] t,
                         input logic [63:0] base, input logic [63:0] pred, input logic exc,
                         input logic fl, input logic rs, input int exp_n, input logic exp_rep);
        exp_t e;
        @(negedge clk_i);
        valid_i           = v;
        taken_i           = t;
        exception_i       = exc;
        predict_address_i = pred;
        flush_i           = fl;
        rst_i             = rs;
        for (int k = 0; k < 4; k++) begin
            addr_i[k]  = base + 64'(4 * k);
            instr_i[k] = mk_instr(base + 64'(4 * k));
        end
        #1;
        chk({tag, "_replay"}, 64'(replay_o), 64'(exp_rep));
        chk({tag, "_raddr"}, replay_addr_o, exp_rep ? base + 64'(4 * exp_n) : 64'h0);
        if (sb.size() == 0 && !fl && !rs) chk({tag, "_nobypass"}, 64'(fetch_entry_valid_o), 64'h0);
        for (int k = 0; k < exp_n; k++) begin
            e.addr  = base + 64'(4 * k);
            e.instr = mk_instr(e.addr);
            e.tk    = t[k] & ~exc;
            e.exv   = exc && (k == 0);
            e.bp    = pred;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        valid_i     = '0;
        taken_i     = '0;
        exception_i = 1'b0;
        flush_i     = 1'b0;
        rst_i       = 1'b0;
    endtask

    // Acknowledge whatever is valid until the scoreboard is empty or the budget expires.
    task automatic drain(input string tag, input bit dual, input int budget);
        exp_t e;
        int   cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk_i);
            fetch_entry_ack_i = '0;
            #1;
            if (fetch_entry_valid_o[0]) begin
                e = sb.pop_front();
                cmp_entry({tag, "_p0"}, fetch_entry_o[0], e);
                fetch_entry_ack_i[0] = 1'b1;
                if (dual && fetch_entry_valid_o[1] && sb.size() > 0) begin
                    e = sb.pop_front();
                    cmp_entry({tag, "_p1"}, fetch_entry_o[1], e);
                    fetch_entry_ack_i[1] = 1'b1;
                end
            end
            cyc++;
        end
        @(negedge clk_i);
        fetch_entry_ack_i = '0;
        #1;
        chk({tag, "_left"}, 64'(sb.size()), 64'h0);
        chk({tag, "_empty"}, 64'(fetch_entry_valid_o), 64'h0);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = '0; taken_i = '0; exception_i = 1'b0;
        instr_i = '0; addr_i = '0; predict_address_i = '0; fetch_entry_ack_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 64'(fetch_entry_valid_o), 64'h0);
        chk("rst_ready", 64'(ready_o), 64'h1);
        chk("rst_replay", 64'(replay_o), 64'h0);
        chk("rst_raddr", replay_addr_o, 64'h0);
        chk("rst_fe_zero", 64'(fetch_entry_o == '0), 64'h1);
        rst_i = 1'b0;

        // Full packet without branches.
        drive("full", 4'b1111, 4'b0000, 64'h1000, 64'h0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        drain("full", 1'b1, 20);

        // Taken branch in lane 1, then a second packet queued behind it.
        drive("tk", 4'b1111, 4'b0010, 64'h1000, 64'h8000, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        drive("tk2", 4'b0011, 4'b0000, 64'h3000, 64'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        @(negedge clk_i);
        #1;
        chk("tk_v", 64'(fetch_entry_valid_o), 64'h3);
        chk("tk_p1addr", fetch_entry_o[1].address, 64'h1004);
        chk("tk_bpv", 64'(fetch_entry_o[1].branch_predict.valid), 64'h1);
        chk("tk_bp", fetch_entry_o[1].branch_predict.predict_address, 64'h8000);
        e_tmp = sb.pop_front();
        cmp_entry("tk_first", fetch_entry_o[0], e_tmp);
        fetch_entry_ack_i = 2'b01;
        @(negedge clk_i);
        fetch_entry_ack_i = '0;
        #1;
        chk("tk_hold", 64'(fetch_entry_valid_o), 64'h1);
        chk("tk_hold_addr", fetch_entry_o[0].address, 64'h1004);
        drain("tk", 1'b1, 20);

        // Bank overflow: banks 0 and 1 full with idx_is at 2.
        drive("ov_a", 4'b0011, 4'b0000, 64'hA000, 64'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        drive("ov_b", 4'b1111, 4'b0000, 64'hB000, 64'h0, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        chk("ov_ready", 64'(ready_o), 64'h0);
        drive("ov_c", 4'b1111, 4'b0000, 64'hC000, 64'h0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        drain("ov", 1'b1, 30);

        // Address FIFO full: four single taken entries, then a taken branch in lane 2.
        for (int i = 0; i < 4; i++) begin
            drive("af_fill", 4'b0001, 4'b0001, 64'hD000 + 64'(i * 16'h100),
                  64'h9000 + 64'(i * 16'h100), 1'b0, 1'b0, 1'b0, 1, 1'b0);
        end
        chk("af_ready", 64'(ready_o), 64'h0);
        drive("af", 4'b1111, 4'b0100, 64'hE000, 64'h7777, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        drain("af", 1'b1, 30);
        drive("af_next", 4'b0001, 4'b0001, 64'hF000, 64'hF000, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        drain("af_next", 1'b1, 10);

        // Instruction page fault on lane 0.
        drive("exc", 4'b1111, 4'b0000, 64'h2000, 64'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        drain("exc", 1'b1, 10);

        // Wrap idx_is through 3 to 1, then flush with a packet present.
        drive("fw_a", 4'b0111, 4'b0000, 64'h6000, 64'h0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        drive("fw_b", 4'b0011, 4'b0000, 64'h6100, 64'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        drive("fw_fl", 4'b1111, 4'b0000, 64'h6200, 64'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        sb.delete();
        chk("fw_fl_valid", 64'(fetch_entry_valid_o), 64'h0);
        chk("fw_fl_ready", 64'(ready_o), 64'h1);
        drive("fw_post", 4'b0001, 4'b0000, 64'h5000, 64'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("fw_post_valid", 64'(fetch_entry_valid_o), 64'h1);
        drain("fw_post", 1'b1, 10);

        // Same sequence ending in reset.
        drive("rw_a", 4'b0111, 4'b0000, 64'h6000, 64'h0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        drive("rw_b", 4'b0011, 4'b0000, 64'h6100, 64'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        drive("rw_rs", 4'b1111, 4'b0000, 64'h6200, 64'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        sb.delete();
        chk("rw_rs_valid", 64'(fetch_entry_valid_o), 64'h0);
        chk("rw_rs_ready", 64'(ready_o), 64'h1);
        drive("rw_post", 4'b0001, 4'b0000, 64'h5100, 64'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("rw_post_valid", 64'(fetch_entry_valid_o), 64'h1);
        drain("rw_post", 1'b1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
